// File: rtl/poly_geom_pkg.sv
// Shared types and width/latency helpers for the polygon geometry engine.
package poly_geom_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CALC,
        ST_OUT
    } state_e;

    function automatic int len_w(input int coord_w);
        return coord_w + 1;
    endfunction

    function automatic int sum_w(input int coord_w, input int num_vert);
        return coord_w + $clog2(num_vert);
    endfunction

    function automatic int sq_w(input int coord_w);
        return 2 * coord_w + 1;
    endfunction

    function automatic int area_w(input int coord_w, input int num_vert);
        return 2 * coord_w + $clog2(num_vert);
    endfunction

    // Lengths take one squaring cycle plus LEN_W root cycles per side; the divider runs alongside.
    function automatic int calc_cyc(input int coord_w, input int num_vert);
        int side_cyc;
        side_cyc = num_vert * (len_w(coord_w) + 1);
        return (side_cyc > sum_w(coord_w, num_vert)) ? side_cyc : sum_w(coord_w, num_vert);
    endfunction

    localparam int CALC_CYC = calc_cyc(5, 3);

endpackage

// File: rtl/poly_isqrt.sv
// Bit-serial floor square root: start pulse loads the radicand, done pulses OUT_W cycles later.
module poly_isqrt
    import poly_geom_pkg::*;
#(
    parameter int IN_W  = 11,
    parameter int OUT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [IN_W-1:0]  radicand_i,
    output logic             done_o,
    output logic [OUT_W-1:0] root_o
);

    localparam int RAD_W = 2 * OUT_W;
    localparam int REM_W = OUT_W + 3;
    localparam int CNT_W = $clog2(OUT_W + 1);

    logic [RAD_W-1:0] rad_q, rad_d, rad_src;
    logic [REM_W-1:0] rem_q, rem_d, rem_src, rem_sh, trial;
    logic [OUT_W-1:0] root_q, root_d, root_src;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, done_q;

    // The start cycle already performs the first iteration on the fresh operand.
    always_comb begin
        rad_src  = start_i ? RAD_W'(radicand_i) : rad_q;
        rem_src  = start_i ? '0 : rem_q;
        root_src = start_i ? '0 : root_q;
        rem_sh   = {rem_src[REM_W-3:0], rad_src[RAD_W-1 -: 2]};
        trial    = REM_W'({root_src, 2'b01});
        rad_d    = rad_src << 2;
        if (rem_sh >= trial) begin
            rem_d  = rem_sh - trial;
            root_d = {root_src[OUT_W-2:0], 1'b1};
        end else begin
            rem_d  = rem_sh;
            root_d = {root_src[OUT_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i || busy_q) begin
                rad_q  <= rad_d;
                rem_q  <= rem_d;
                root_q <= root_d;
                cnt_q  <= start_i ? CNT_W'(1) : cnt_q + CNT_W'(1);
                busy_q <= 1'b1;
                if (!start_i && cnt_q == CNT_W'(OUT_W - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o = done_q;
    assign root_o = root_q;

endmodule

// File: rtl/polygon_geom_engine.sv
// Serial polygon side lengths and floor vertex centroid; optional POLY_AREA_EN adds twice the shoelace area.
module polygon_geom_engine
    import poly_geom_pkg::*;
#(
    parameter int COORD_W  = 5,
    parameter int NUM_VERT = 3,
    parameter int LEN_W    = len_w(COORD_W),
    parameter int SUM_W    = sum_w(COORD_W, NUM_VERT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [COORD_W-1:0]     coord_x,
    input  logic [COORD_W-1:0]     coord_y,
    output logic                   out_valid,
    output logic [LEN_W-1:0]       out_length,
    output logic [2*COORD_W-1:0]   out_center
`ifdef POLY_AREA_EN
    ,
    output logic [2*COORD_W+$clog2(NUM_VERT)-1:0] out_area
`endif
);

    localparam int N      = NUM_VERT;
    localparam int IDX_W  = $clog2(N);
    localparam int SIDE_W = $clog2(N + 1);
    localparam int SQ_W   = sq_w(COORD_W);
    localparam int CYC    = calc_cyc(COORD_W, N);
    localparam int CNT_W  = $clog2(CYC + 1);
    localparam int PH_W   = $clog2(LEN_W + 1);
    localparam int BEAT_W = $clog2(N + 2);
    localparam logic [SUM_W:0] N_EXT = (SUM_W + 1)'(N);

    state_e               state_q;
    logic [COORD_W-1:0]   vx_q [N];
    logic [COORD_W-1:0]   vy_q [N];
    logic [LEN_W-1:0]     len_q [N];
    logic [IDX_W-1:0]     vcnt_q, len_idx_q;
    logic [SUM_W-1:0]     sumx_q, sumy_q, remx_q, remy_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [SIDE_W-1:0]    side_q;
    logic [PH_W-1:0]      ph_q;
    logic [BEAT_W-1:0]    beat_q;
    logic [SQ_W-1:0]      sq_q, sq_d;
    logic                 start_q;
    logic                 out_valid_q;
    logic [LEN_W-1:0]     out_length_q;
    logic [2*COORD_W-1:0] out_center_q;
    logic                 sqrt_done;
    logic [LEN_W-1:0]     sqrt_root;
    logic [IDX_W-1:0]     ia, ib;
    logic [COORD_W-1:0]   dx, dy;

`ifdef POLY_AREA_EN
    localparam int AREA_W = area_w(COORD_W, N);
    localparam int ACC_W  = AREA_W + 2;
    logic [ACC_W-1:0]  area_acc_q, area_term_d, area_abs;
    logic [AREA_W-1:0] out_area_q;
`endif

    // Shifts one dividend bit into the remainder; the quotient bit replaces it at the LSB.
    function automatic logic [2*SUM_W-1:0] div_step(input logic [SUM_W-1:0] rem,
                                                    input logic [SUM_W-1:0] dvd);
        logic [SUM_W:0] r;
        r = {rem, dvd[SUM_W-1]};
        if (r >= N_EXT)
            return {SUM_W'(r - N_EXT), dvd[SUM_W-2:0], 1'b1};
        return {r[SUM_W-1:0], dvd[SUM_W-2:0], 1'b0};
    endfunction

    always_comb begin
        ia   = side_q[IDX_W-1:0];
        ib   = (ia == IDX_W'(N - 1)) ? '0 : ia + IDX_W'(1);
        dx   = (vx_q[ia] >= vx_q[ib]) ? vx_q[ia] - vx_q[ib] : vx_q[ib] - vx_q[ia];
        dy   = (vy_q[ia] >= vy_q[ib]) ? vy_q[ia] - vy_q[ib] : vy_q[ib] - vy_q[ia];
        sq_d = SQ_W'(dx) * SQ_W'(dx) + SQ_W'(dy) * SQ_W'(dy);
`ifdef POLY_AREA_EN
        area_term_d = ACC_W'(vx_q[ia]) * ACC_W'(vy_q[ib]) - ACC_W'(vx_q[ib]) * ACC_W'(vy_q[ia]);
        area_abs    = area_acc_q[ACC_W-1] ? -area_acc_q : area_acc_q;
`endif
    end

    poly_isqrt #(
        .IN_W  (SQ_W),
        .OUT_W (LEN_W)
    ) u_isqrt (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_q),
        .radicand_i (sq_q),
        .done_o     (sqrt_done),
        .root_o     (sqrt_root)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < N; i++) begin
                vx_q[i]  <= '0;
                vy_q[i]  <= '0;
                len_q[i] <= '0;
            end
            vcnt_q       <= '0;
            len_idx_q    <= '0;
            sumx_q       <= '0;
            sumy_q       <= '0;
            remx_q       <= '0;
            remy_q       <= '0;
            cnt_q        <= '0;
            side_q       <= '0;
            ph_q         <= '0;
            beat_q       <= '0;
            sq_q         <= '0;
            start_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_length_q <= '0;
            out_center_q <= '0;
`ifdef POLY_AREA_EN
            area_acc_q   <= '0;
            out_area_q   <= '0;
`endif
        end else begin
            start_q <= 1'b0;
            // The last side's root lands during the first OUT beat, well before it is emitted.
            if (sqrt_done) begin
                len_q[len_idx_q] <= sqrt_root;
                len_idx_q        <= len_idx_q + IDX_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        vx_q[0] <= coord_x;
                        vy_q[0] <= coord_y;
                        sumx_q  <= SUM_W'(coord_x);
                        sumy_q  <= SUM_W'(coord_y);
                        vcnt_q  <= IDX_W'(1);
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!in_valid) begin
                        state_q <= ST_IDLE;
                    end else begin
                        vx_q[vcnt_q] <= coord_x;
                        vy_q[vcnt_q] <= coord_y;
                        sumx_q       <= sumx_q + SUM_W'(coord_x);
                        sumy_q       <= sumy_q + SUM_W'(coord_y);
                        vcnt_q       <= vcnt_q + IDX_W'(1);
                        if (vcnt_q == IDX_W'(N - 1)) begin
                            state_q   <= ST_CALC;
                            cnt_q     <= '0;
                            side_q    <= '0;
                            ph_q      <= '0;
                            len_idx_q <= '0;
                            remx_q    <= '0;
                            remy_q    <= '0;
`ifdef POLY_AREA_EN
                            area_acc_q <= '0;
`endif
                        end
                    end
                end
                ST_CALC: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q < CNT_W'(SUM_W)) begin
                        {remx_q, sumx_q} <= div_step(remx_q, sumx_q);
                        {remy_q, sumy_q} <= div_step(remy_q, sumy_q);
                    end
                    if (side_q < SIDE_W'(N)) begin
                        if (ph_q == '0) begin
                            sq_q    <= sq_d;
                            start_q <= 1'b1;
`ifdef POLY_AREA_EN
                            area_acc_q <= area_acc_q + area_term_d;
`endif
                        end
                        if (ph_q == PH_W'(LEN_W)) begin
                            ph_q   <= '0;
                            side_q <= side_q + SIDE_W'(1);
                        end else begin
                            ph_q <= ph_q + PH_W'(1);
                        end
                    end
                    if (cnt_q == CNT_W'(CYC - 1)) begin
                        state_q      <= ST_OUT;
                        beat_q       <= '0;
                        out_valid_q  <= 1'b1;
                        out_length_q <= len_q[0];
                    end
                end
                ST_OUT: begin
                    beat_q <= beat_q + BEAT_W'(1);
                    if (beat_q < BEAT_W'(N - 1)) begin
                        out_length_q <= len_q[IDX_W'(beat_q + BEAT_W'(1))];
                    end else if (beat_q == BEAT_W'(N - 1)) begin
                        out_length_q <= '0;
                        out_center_q <= {sumy_q[COORD_W-1:0], sumx_q[COORD_W-1:0]};
`ifdef POLY_AREA_EN
                        out_area_q   <= area_abs[AREA_W-1:0];
`endif
                    end else begin
                        out_valid_q  <= 1'b0;
                        out_center_q <= '0;
`ifdef POLY_AREA_EN
                        out_area_q   <= '0;
`endif
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_length = out_length_q;
    assign out_center = out_center_q;
`ifdef POLY_AREA_EN
    assign out_area   = out_area_q;
`endif

endmodule

// File: tb/tb_polygon_geom_engine.sv
// Directed bench for polygon_geom_engine: a NUM_VERT=3 and a NUM_VERT=4 instance share the vertex stream.
module tb_polygon_geom_engine;

    localparam int CYC3 = 21;  // max(3*(6+1), 7)
    localparam int CYC4 = 28;  // max(4*(6+1), 7)

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [4:0] coord_x = '0;
    logic [4:0] coord_y = '0;
    logic       ov3, ov4;
    logic [5:0] len3, len4;
    logic [9:0] cen3, cen4;
`ifdef POLY_AREA_EN
    logic [11:0] area3, area4;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_cyc = 0;
    int dsel = 0;
    int vx[4], vy[4], el[4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    polygon_geom_engine #(.COORD_W(5), .NUM_VERT(3)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .coord_x    (coord_x),
        .coord_y    (coord_y),
        .out_valid  (ov3),
        .out_length (len3),
        .out_center (cen3)
`ifdef POLY_AREA_EN
        ,
        .out_area   (area3)
`endif
    );

    polygon_geom_engine #(.COORD_W(5), .NUM_VERT(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .coord_x    (coord_x),
        .coord_y    (coord_y),
        .out_valid  (ov4),
        .out_length (len4),
        .out_center (cen4)
`ifdef POLY_AREA_EN
        ,
        .out_area   (area4)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic sel_ov();
        return (dsel == 4) ? ov4 : ov3;
    endfunction

    function automatic logic [31:0] sel_len();
        return (dsel == 4) ? 32'(len4) : 32'(len3);
    endfunction

    function automatic logic [31:0] sel_cen();
        return (dsel == 4) ? 32'(cen4) : 32'(cen3);
    endfunction

`ifdef POLY_AREA_EN
    function automatic logic [31:0] sel_area();
        return (dsel == 4) ? 32'(area4) : 32'(area3);
    endfunction
`endif

    // Drives nv vertices from vx/vy, then 'extra' cycles of junk with in_valid held high.
    task automatic drive_frame(input int nv, input int extra);
        for (int v = 0; v < nv; v++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            coord_x  = 5'(vx[v]);
            coord_y  = 5'(vy[v]);
            last_cyc = cyc;
        end
        for (int k = 0; k < extra; k++) begin
            @(posedge clk); #1;
            coord_x = 5'(13 + k);
            coord_y = 5'(29 - k);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        coord_x  = '0;
        coord_y  = '0;
    endtask

    task automatic run_frame(input string tag, input int sel, input int nv, input int extra,
                             input int cx, input int cy, input int area, input int calc);
        int waited;
        dsel = sel;
        drive_frame(nv, extra);
        waited = 0;
        while (!sel_ov() && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check_val({tag, " out_valid seen"}, 32'(sel_ov()), 1);
        check_val({tag, " latency"}, 32'(cyc - last_cyc), 32'(calc + 1));
        for (int b = 0; b <= nv; b++) begin
            check_val($sformatf("%s beat%0d valid", tag, b), 32'(sel_ov()), 1);
            check_val($sformatf("%s beat%0d length", tag, b), sel_len(), (b < nv) ? 32'(el[b]) : 0);
            check_val($sformatf("%s beat%0d center", tag, b), sel_cen(), (b < nv) ? 0 : 32'(cy * 32 + cx));
`ifdef POLY_AREA_EN
            check_val($sformatf("%s beat%0d area", tag, b), sel_area(), (b < nv) ? 0 : 32'(area));
`endif
            @(negedge clk);
        end
        check_val({tag, " valid after"}, 32'(sel_ov()), 0);
        check_val({tag, " length after"}, sel_len(), 0);
        check_val({tag, " center after"}, sel_cen(), 0);
        $display("frame %s: dut N=%0d, %0d vertices, center {%0d,%0d}, area %0d", tag, sel, nv, cy, cx, area);
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        int hits = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (ov3 || ov4) hits++;
        end
        check_val({tag, " no beats"}, 32'(hits), 0);
    endtask

    task automatic set_tri1();
        vx = '{0, 3, 0, 0}; vy = '{0, 0, 4, 0};
        el = '{3, 5, 4, 0};  // sides in order V0V1, V1V2, V2V0
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("reset valid", 32'(ov3), 0);
        check_val("reset length", 32'(len3), 0);
        check_val("reset center", 32'(cen3), 0);
        check_val("reset valid n4", 32'(ov4), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        set_tri1();
        run_frame("t1 right triangle", 3, 3, 0, 1, 1, 12, CYC3);

        vx = '{31, 0, 31, 0}; vy = '{31, 0, 0, 0}; el = '{43, 31, 31, 0};
        run_frame("t2 max coords + junk", 3, 3, 5, 20, 10, 961, CYC3);
        repeat (40) @(negedge clk);

        vx = '{7, 7, 7, 0}; vy = '{7, 7, 7, 0}; el = '{0, 0, 0, 0};
        run_frame("t3 coincident", 3, 3, 0, 7, 7, 0, CYC3);

        vx = '{1, 2, 0, 0}; vy = '{1, 2, 0, 0};
        drive_frame(2, 0);
        watch_quiet("t4 short frame", 40);
        $display("frame t4 short frame: discarded");
        set_tri1();
        run_frame("t4 follow-up", 3, 3, 0, 1, 1, 12, CYC3);

        drive_frame(3, 0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("t5 calc reset valid", 32'(ov3), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        watch_quiet("t5 calc reset", 40);
        $display("frame t5 reset mid-calc: aborted");

        drive_frame(3, 0);
        repeat (CYC3 + 2) @(negedge clk);
        check_val("t5b out active", 32'(ov3), 1);
        rst_n = 1'b0;
        #1;
        check_val("t5b reset valid", 32'(ov3), 0);
        check_val("t5b reset length", 32'(len3), 0);
        check_val("t5b reset center", 32'(cen3), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        watch_quiet("t5b out reset", 40);
        $display("frame t5b reset mid-out: aborted");
        run_frame("t5 follow-up", 3, 3, 0, 1, 1, 12, CYC3);
        repeat (40) @(negedge clk);

        vx = '{0, 10, 10, 0}; vy = '{0, 0, 10, 10}; el = '{10, 10, 10, 10};
        run_frame("t6 square n4", 4, 4, 0, 5, 5, 200, CYC4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
